reg_file_2r1w: RTL

Parametrised register file with one write port and two independent read ports. It is the next-generation replacement for the single-port 8x16 register file. It adds:
- width, depth and address generics
- a bit-level write mask
- per-port read-valid and out-of-range error flags
- write-first bypass on same-cycle read/write collisions

It sits between the control/ALU datapath and the system bus as general-purpose configuration and scratch storage.

---
 rtl/reg_file_2r1w.sv | 88 ++++++++
 1 files changed

// File: rtl/reg_file_2r1w.sv
// Register file: one masked write port, two registered read ports with
// write-first bypass, per-port valid/error flags and out-of-range detection.
module reg_file_2r1w #(
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    ADDR_WIDTH  = 4,
   parameter int                    DEPTH       = 16,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  WrEn,
   input  logic [ADDR_WIDTH-1:0] WrAddr,
   input  logic [DATA_WIDTH-1:0] WrData,
   input  logic [DATA_WIDTH-1:0] WrMask,
   input  logic                  RdEnA,
   input  logic [ADDR_WIDTH-1:0] RdAddrA,
   output logic [DATA_WIDTH-1:0] RdDataA,
   output logic                  RdValidA,
   output logic                  RdErrA,
   input  logic                  RdEnB,
   input  logic [ADDR_WIDTH-1:0] RdAddrB,
   output logic [DATA_WIDTH-1:0] RdDataB,
   output logic                  RdValidB,
   output logic                  RdErrB,
   output logic                  WrErr
);

   localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  wr_ok;
   logic [IDX_W-1:0]      wr_idx;
   logic [DATA_WIDTH-1:0] wr_merged;
   logic                  rd_ok_a;
   logic                  rd_ok_b;
   logic [DATA_WIDTH-1:0] rd_val_a;
   logic [DATA_WIDTH-1:0] rd_val_b;

   // Reads see the merged post-write value when they hit the entry being written.
   always_comb begin
      wr_idx    = WrAddr[IDX_W-1:0];
      wr_ok     = WrEn && ({1'b0, WrAddr} < DEPTH_W);
      wr_merged = (mem[wr_idx] & ~WrMask) | (WrData & WrMask);

      rd_ok_a  = {1'b0, RdAddrA} < DEPTH_W;
      rd_val_a = '0;
      if (rd_ok_a) begin
         if (wr_ok && (WrAddr == RdAddrA)) rd_val_a = wr_merged;
         else                              rd_val_a = mem[RdAddrA[IDX_W-1:0]];
      end

      rd_ok_b  = {1'b0, RdAddrB} < DEPTH_W;
      rd_val_b = '0;
      if (rd_ok_b) begin
         if (wr_ok && (WrAddr == RdAddrB)) rd_val_b = wr_merged;
         else                              rd_val_b = mem[RdAddrB[IDX_W-1:0]];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VALUE;
         RdDataA  <= '0;
         RdValidA <= 1'b0;
         RdErrA   <= 1'b0;
         RdDataB  <= '0;
         RdValidB <= 1'b0;
         RdErrB   <= 1'b0;
         WrErr    <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_ok && (wr_idx == IDX_W'(i))) mem[i] <= wr_merged;
         end
         WrErr <= WrEn && !wr_ok;

         RdValidA <= RdEnA;
         RdErrA   <= RdEnA && !rd_ok_a;
         if (RdEnA) RdDataA <= rd_val_a;

         RdValidB <= RdEnB;
         RdErrB   <= RdEnB && !rd_ok_b;
         if (RdEnB) RdDataB <= rd_val_b;
      end
   end

endmodule
